// File: rtl/seq_multiplier_param.sv
// Radix-2 shift-add WIDTH x WIDTH multiplier, signed/unsigned per op; SATURATE_EN clamps Z on overflow.
// Latency: out_valid rises WIDTH edges after accept; one result per WIDTH+1 cycles.
// Backpressure: result held while out_ready=0; in_ready low in BUSY and in DONE until out_ready.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Z,
  output logic [2*WIDTH-1:0] P,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic             sgn_mode;
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [WIDTH:0]     sum;

  // Next-state and handshake
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept    = in_valid && in_ready;
    last_step = (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A most-negative operand negates to itself, which is already its correct unsigned magnitude.
  always_comb begin
    x_mag = (is_signed && X[WIDTH-1]) ? -X : X;
    y_mag = (is_signed && Y[WIDTH-1]) ? -Y : Y;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (op_q.mplier[0] ? {1'b0, op_q.mcand} : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q.mcand    <= x_mag;
      op_q.mplier   <= y_mag;
      op_q.neg      <= is_signed && (X[WIDTH-1] ^ Y[WIDTH-1]);
      op_q.sgn_mode <= is_signed;
      acc_q         <= '0;
      cnt_q         <= '0;
    end else if (state_q == BUSY) begin
      acc_q       <= {sum, acc_q[WIDTH-1:1]};
      op_q.mplier <= op_q.mplier >> 1;
      cnt_q       <= cnt_q + 1'b1;
    end
  end

  assign out_valid = (state_q == DONE);

  // Sign is applied to the finished magnitude; a zero magnitude negates to zero.
  always_comb begin
    P = op_q.neg ? -acc_q : acc_q;
    if (op_q.sgn_mode)
      overflow = (|P[2*WIDTH-1:WIDTH-1]) && !(&P[2*WIDTH-1:WIDTH-1]);
    else
      overflow = |P[2*WIDTH-1:WIDTH];
`ifdef SATURATE_EN
    if (overflow) begin
      if (!op_q.sgn_mode) Z = '1;
      else if (op_q.neg)  Z = {1'b1, {(WIDTH-1){1'b0}}};
      else                Z = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      Z = P[WIDTH-1:0];
    end
`else
    Z = P[WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed WIDTH=8 checks plus randomized WIDTH=16 operations against an arithmetic reference model.
module tb_seq_multiplier_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        iv8, ir8, s8, ov8, or8, of8;
  logic [7:0]  x8, y8, z8;
  logic [15:0] p8;

  logic        iv16, ir16, s16, ov16, or16, of16;
  logic [15:0] x16, y16, z16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .X(x8), .Y(y8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .Z(z8), .P(p8), .overflow(of8)
  );

  seq_multiplier_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .X(x16), .Y(y16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .Z(z16), .P(p16), .overflow(of16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the interpreted operand values.
  function automatic void ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit sgn, output logic [63:0] p, output logic ov,
                                  output logic [31:0] z);
    longint one, av, bv, prod, mask_w, mask_2w, hi, lo;
    one     = 64'sd1;
    mask_w  = (one <<< w) - 1;
    mask_2w = (one <<< (2 * w)) - 1;
    av = longint'(a) & mask_w;
    bv = longint'(b) & mask_w;
    if (sgn) begin
      if (av >= (one <<< (w - 1))) av = av - (one <<< w);
      if (bv >= (one <<< (w - 1))) bv = bv - (one <<< w);
    end
    prod = av * bv;
    hi = sgn ? (one <<< (w - 1)) - 1 : mask_w;
    lo = sgn ? -(one <<< (w - 1)) : 64'sd0;
    ov = (prod > hi) || (prod < lo);
    p  = 64'(prod & mask_2w);
    z  = 32'(prod & mask_w);
`ifdef SATURATE_EN
    if (ov) z = 32'(prod < 0 ? (one <<< (w - 1)) : hi);
`endif
  endfunction

  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s);
    @(negedge clk);
    iv8 = 1'b1; x8 = x; y8 = y; s8 = s;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take8();
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                     input logic [15:0] ep, input logic [7:0] ez, input logic eo);
    int lat;
    start8(x, y, s);
    wait_done8(lat);
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_P"}, 64'(p8), 64'(ep));
    check({tag, "_Z"}, 64'(z8), 64'(ez));
    check({tag, "_ovf"}, 64'(of8), 64'(eo));
    check({tag, "_inrdy"}, 64'(ir8), 64'd0);
    take8();
  endtask

  initial begin
    logic [7:0]  z_16x16, z_m128;
    logic [63:0] ep;
    logic [31:0] ez;
    logic        eo;
    int          lat, n, d;
`ifdef SATURATE_EN
    z_16x16 = 8'hFF; z_m128 = 8'h7F;
`else
    z_16x16 = 8'h00; z_m128 = 8'h80;
`endif
    reset = 1'b1;
    iv8 = 0; or8 = 0; s8 = 0; x8 = 0; y8 = 0;
    iv16 = 0; or16 = 0; s16 = 0; x16 = 0; y16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_inrdy", 64'(ir8), 64'd1);
    check("rst_outvld", 64'(ov8), 64'd0);
    check("rst_Z", 64'(z8), 64'd0);
    check("rst_P", 64'(p8), 64'd0);
    check("rst_ovf", 64'(of8), 64'd0);

    op8("u15x17", 8'd15, 8'd17, 1'b0, 16'h00FF, 8'hFF, 1'b0);
    op8("u16x16", 8'd16, 8'd16, 1'b0, 16'h0100, z_16x16, 1'b1);
    op8("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 8'hF1, 1'b0);
    op8("s_m128xm1", 8'h80, 8'hFF, 1'b1, 16'h0080, z_m128, 1'b1);
    op8("s_0xneg", 8'h00, 8'h85, 1'b1, 16'h0000, 8'h00, 1'b0);
    op8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, (z_16x16 == 8'hFF) ? 8'hFF : 8'h01, 1'b1);

    // Backpressure, then back-to-back accept
    start8(8'd12, 8'd11, 1'b0);
    wait_done8(lat);
    check("bp_lat", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_outvld", 64'(ov8), 64'd1);
      check("bp_P", 64'(p8), 64'h0084);
      check("bp_Z", 64'(z8), 64'h84);
      check("bp_inrdy", 64'(ir8), 64'd0);
    end
    or8 = 1'b1; iv8 = 1'b1; x8 = 8'd3; y8 = 8'd5; s8 = 1'b0;
    #1;
    check("b2b_inrdy", 64'(ir8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b0;
    check("b2b_outvld_drop", 64'(ov8), 64'd0);
    wait_done8(lat);
    check("b2b_lat", 64'(lat), 64'd8);
    check("b2b_P", 64'(p8), 64'd15);
    take8();
    check("take_idle_inrdy", 64'(ir8), 64'd1);
    check("take_outvld", 64'(ov8), 64'd0);

    // Reset on the fourth BUSY edge
    start8(8'd200, 8'd200, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mrst_inrdy", 64'(ir8), 64'd1);
    check("mrst_outvld", 64'(ov8), 64'd0);
    check("mrst_P", 64'(p8), 64'd0);
    repeat (10) @(negedge clk);
    check("mrst_stay_idle", 64'(ov8), 64'd0);
    op8("after_rst_3x3", 8'd3, 8'd3, 1'b0, 16'h0009, 8'h09, 1'b0);

    // Randomized WIDTH=16 operations with random sink stalls
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      x16 = 16'($urandom_range(0, 65535));
      y16 = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) x16 = 16'h8000;
      if ($urandom_range(0, 19) == 0) y16 = 16'h0000;
      s16 = 1'($urandom_range(0, 1));
      iv16 = 1'b1;
      ref_mul(16, 32'(x16), 32'(y16), s16, ep, eo, ez);
      n = 0;
      while (!ir16 && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 50) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      check("r16_lat", 64'(n), 64'd16);
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      check("r16_P", 64'(p16), ep);
      check("r16_ovf", 64'(of16), 64'(eo));
      check("r16_Z", 64'(z16), 64'(ez));
      or16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or16 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
